// File: rtl/cordic_rr_scheduler.sv
// Round-robin issue scheduler that shares one pipelined CORDIC cosine core among NREQ requesters.
// A {valid, id} tag travels alongside each operand so that every result returns to the requester that issued it.
module cordic_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 4,
  parameter int IDW     = 3
) (
  input  logic                 clock,
  input  logic                 aclr,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      grant,
  input  logic                 hold,
  output logic                 cordic_clk_en,
  output logic                 cordic_aclr,
  output logic [31:0]          cordic_dataa,
  input  logic [31:0]          cordic_result,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_data,
  output logic                 busy
);

  logic [IDW-1:0]     r_ptr;
  logic [LATENCY-1:0] r_tagValid;
  logic [IDW-1:0]     r_tagId [LATENCY];
  logic [NREQ-1:0]    r_respValid;
  logic [31:0]        r_respData;

  logic [NREQ-1:0]    w_hiReq;
  logic [NREQ-1:0]    w_pickVec;
  logic [IDW-1:0]     w_grantIdx;
  logic               w_grantAny;
  logic [NREQ-1:0]    w_grant;
  logic [31:0]        w_dataa;
  logic [IDW-1:0]     w_nextPtr;

  // Requesters at or above the pointer win first; if none, wrap to the lowest requester overall.
  always_comb begin
    w_hiReq = '0;
    for (int j = 0; j < NREQ; j++) begin
      w_hiReq[j] = req[j] && (IDW'(j) >= r_ptr);
    end
    w_pickVec = (|w_hiReq) ? w_hiReq : req;
    w_grantIdx = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (w_pickVec[j]) begin
        w_grantIdx = IDW'(j);
      end
    end
    w_grantAny = (|req) && !hold && !aclr;
    w_grant = w_grantAny ? (NREQ'(1) << w_grantIdx) : '0;
  end

  always_comb begin
    w_dataa = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_grant[j]) begin
        w_dataa = req_data[32*j +: 32];
      end
    end
  end

  assign w_nextPtr = (w_grantIdx == IDW'(NREQ - 1)) ? '0 : (w_grantIdx + IDW'(1));

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_ptr <= '0;
    end else if (w_grantAny) begin
      r_ptr <= w_nextPtr;
    end
  end

  // Tag pipe moves in lockstep with the core's clock enable; empty cycles enter as bubbles.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_tagValid <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        r_tagId[k] <= '0;
      end
    end else if (!hold) begin
      r_tagValid[0] <= w_grantAny;
      r_tagId[0]    <= w_grantIdx;
      for (int k = 1; k < LATENCY; k++) begin
        r_tagValid[k] <= r_tagValid[k-1];
        r_tagId[k]    <= r_tagId[k-1];
      end
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_respValid <= '0;
      r_respData  <= '0;
    end else if (!hold && r_tagValid[LATENCY-1]) begin
      r_respValid <= NREQ'(1) << r_tagId[LATENCY-1];
      r_respData  <= cordic_result;
    end else begin
      r_respValid <= '0;
    end
  end

  assign grant         = w_grant;
  assign cordic_dataa  = w_dataa;
  assign cordic_clk_en = ~hold;
  assign cordic_aclr   = aclr;
  assign resp_valid    = r_respValid;
  assign resp_data     = r_respData;
  assign busy          = |r_tagValid;

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Bench for cordic_rr_scheduler: directed vector table, hand-written reset sequence, then random traffic
// checked against a queue-based model of issue order and result latency. A stand-in core XORs the operand.
module tb_cordic_rr_scheduler;

  localparam int NREQ    = 4;
  localparam int LATENCY = 4;
  localparam int IDW     = 3;
  localparam logic [31:0] CORE_XOR = 32'hA5A5_0F0F;

  logic              clock = 1'b0;
  logic              aclr;
  logic [NREQ-1:0]   req;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]   grant;
  logic              hold;
  logic              cordic_clk_en;
  logic              cordic_aclr;
  logic [31:0]       cordic_dataa;
  logic [31:0]       cordic_result;
  logic [NREQ-1:0]   resp_valid;
  logic [31:0]       resp_data;
  logic              busy;

  int nVectors = 0;
  int nMiscompares = 0;

  always #5 clock = ~clock;

  cordic_rr_scheduler #(.NREQ(NREQ), .LATENCY(LATENCY), .IDW(IDW)) dut (
    .clock(clock), .aclr(aclr), .req(req), .req_data(req_data), .grant(grant),
    .hold(hold), .cordic_clk_en(cordic_clk_en), .cordic_aclr(cordic_aclr),
    .cordic_dataa(cordic_dataa), .cordic_result(cordic_result),
    .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy)
  );

  // Stand-in for the cosine core: a LATENCY-deep enabled pipe with a recognisable transform.
  logic [31:0] corePipe [LATENCY];
  always_ff @(posedge clock or posedge cordic_aclr) begin
    if (cordic_aclr) begin
      for (int k = 0; k < LATENCY; k++) corePipe[k] <= '0;
    end else if (cordic_clk_en) begin
      corePipe[0] <= cordic_dataa;
      for (int k = 1; k < LATENCY; k++) corePipe[k] <= corePipe[k-1];
    end
  end
  assign cordic_result = corePipe[LATENCY-1] ^ CORE_XOR;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          tick;
  } op_t;

  op_t         mQ[$];
  int          mPtr;
  int          mTick;
  logic [3:0]  mRespValid;
  logic [31:0] mRespData;
  logic [31:0] tbData [NREQ];

  typedef struct {
    logic [3:0] req;
    logic       hold;
    logic [3:0] expGrant;
    logic [3:0] expResp;
    logic       expBusy;
  } vec_t;

  vec_t tbl [41];

  task automatic modelReset();
    mQ.delete();
    mPtr = 0;
    mTick = 0;
    mRespValid = '0;
    mRespData = '0;
  endtask

  // First requesting index scanning from the pointer, or -1 if nothing may be granted.
  function automatic int modelPick(input logic [3:0] r, input logic h, input logic a);
    int idx;
    if (h || a) return -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (mPtr + k) % NREQ;
      if (r[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  // Each op is stamped with the count of advancing edges at issue and answers LATENCY advancing edges later.
  task automatic modelEdge(input logic [3:0] r, input logic h);
    int  g;
    op_t o;
    g = modelPick(r, h, 1'b0);
    mRespValid = '0;
    if (h) return;
    if (mQ.size() > 0 && (mTick - mQ[0].tick) == LATENCY) begin
      o = mQ.pop_front();
      mRespValid = 4'b0001 << o.id;
      mRespData = o.data ^ CORE_XOR;
    end
    if (g >= 0) begin
      mQ.push_back('{g, tbData[g], mTick});
      mPtr = (g + 1) % NREQ;
    end
    mTick++;
  endtask

  task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic h);
    @(negedge clock);
    req = r;
    hold = h;
    for (int i = 0; i < NREQ; i++) begin
      tbData[i] = $urandom;
      req_data[32*i +: 32] = tbData[i];
    end
    #1;
  endtask

  task automatic checkOutput();
    int          g;
    logic [3:0]  expGrant;
    logic [31:0] expData;
    g = modelPick(req, hold, aclr);
    expGrant = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    expData = (g >= 0) ? tbData[g] : 32'h0;
    checkOne("grant", {28'h0, grant}, {28'h0, expGrant});
    checkOne("dataa", cordic_dataa, expData);
    checkOne("clkEn", {31'h0, cordic_clk_en}, {31'h0, ~hold});
    checkOne("coreAclr", {31'h0, cordic_aclr}, {31'h0, aclr});
    checkOne("respValid", {28'h0, resp_valid}, {28'h0, mRespValid});
    checkOne("respData", resp_data, mRespData);
    checkOne("busy", {31'h0, busy}, {31'h0, (mQ.size() != 0)});
  endtask

  task automatic doCycle(input logic [3:0] r, input logic h);
    applyStimulus(r, h);
    checkOutput();
    modelEdge(r, h);
  endtask

  // Reset pulse wholly between two rising edges, with no request pending.
  task automatic resetPulse();
    applyStimulus(4'b0000, 1'b0);
    aclr = 1'b1;
    #1;
    modelReset();
    checkOutput();
    checkOne("rstRespValid", {28'h0, resp_valid}, 32'h0);
    checkOne("rstBusy", {31'h0, busy}, 32'h0);
    #1;
    aclr = 1'b0;
    modelEdge(4'b0000, 1'b0);
  endtask

  initial begin
    // Fairness from pointer 0
    tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 4'b0000, 1'b0};
    tbl[1]  = '{4'b1111, 1'b0, 4'b0010, 4'b0000, 1'b1};
    tbl[2]  = '{4'b1111, 1'b0, 4'b0100, 4'b0000, 1'b1};
    tbl[3]  = '{4'b1111, 1'b0, 4'b1000, 4'b0000, 1'b1};
    tbl[4]  = '{4'b1111, 1'b0, 4'b0001, 4'b0000, 1'b1};
    tbl[5]  = '{4'b1111, 1'b0, 4'b0010, 4'b0001, 1'b1};
    tbl[6]  = '{4'b1111, 1'b0, 4'b0100, 4'b0010, 1'b1};
    tbl[7]  = '{4'b1111, 1'b0, 4'b1000, 4'b0100, 1'b1};
    tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 4'b1000, 1'b1};
    tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 4'b0001, 1'b1};
    tbl[10] = '{4'b0000, 1'b0, 4'b0000, 4'b0010, 1'b1};
    tbl[11] = '{4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b1};
    tbl[12] = '{4'b0000, 1'b0, 4'b0000, 4'b1000, 1'b0};
    tbl[13] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    // Single issue from requester 0
    tbl[14] = '{4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b0};
    tbl[15] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[16] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[17] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[18] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[19] = '{4'b0000, 1'b0, 4'b0000, 4'b0001, 1'b0};
    // Hold mid-flight on a requester-2 op; requester 1 asks only during hold, then withdraws
    tbl[20] = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b0};
    tbl[21] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[22] = '{4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b1};
    tbl[23] = '{4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b1};
    tbl[24] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[25] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[26] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[27] = '{4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b0};
    tbl[28] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
    // Wrap after requester 3, skip idle requesters, grant and response to one requester together
    tbl[29] = '{4'b1000, 1'b0, 4'b1000, 4'b0000, 1'b0};
    tbl[30] = '{4'b0101, 1'b0, 4'b0001, 4'b0000, 1'b1};
    tbl[31] = '{4'b0101, 1'b0, 4'b0100, 4'b0000, 1'b1};
    tbl[32] = '{4'b0101, 1'b0, 4'b0001, 4'b0000, 1'b1};
    tbl[33] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[34] = '{4'b1000, 1'b0, 4'b1000, 4'b1000, 1'b1};
    tbl[35] = '{4'b0000, 1'b0, 4'b0000, 4'b0001, 1'b1};
    tbl[36] = '{4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b1};
    tbl[37] = '{4'b0000, 1'b0, 4'b0000, 4'b0001, 1'b1};
    tbl[38] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1};
    tbl[39] = '{4'b0000, 1'b0, 4'b0000, 4'b1000, 1'b0};
    tbl[40] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};

    aclr = 1'b1;
    hold = 1'b0;
    req = 4'b1111;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) tbData[i] = '0;
    modelReset();

    @(negedge clock);
    for (int i = 0; i < NREQ; i++) begin
      tbData[i] = $urandom;
      req_data[32*i +: 32] = tbData[i];
    end
    #1;
    checkOutput();
    hold = 1'b1;
    #1;
    checkOutput();
    req = 4'b0000;
    hold = 1'b0;
    #1;
    aclr = 1'b0;

    for (int t = 0; t < 41; t++) begin
      applyStimulus(tbl[t].req, tbl[t].hold);
      checkOutput();
      checkOne($sformatf("tblGrant[%0d]", t), {28'h0, grant}, {28'h0, tbl[t].expGrant});
      checkOne($sformatf("tblResp[%0d]", t), {28'h0, resp_valid}, {28'h0, tbl[t].expResp});
      checkOne($sformatf("tblBusy[%0d]", t), {31'h0, busy}, {31'h0, tbl[t].expBusy});
      modelEdge(tbl[t].req, tbl[t].hold);
    end

    // Three ops in flight, then reset: none of them may ever answer, pointer returns to 0
    doCycle(4'b1111, 1'b0);
    doCycle(4'b1111, 1'b0);
    doCycle(4'b1111, 1'b0);
    resetPulse();
    for (int c = 0; c < 6; c++) begin
      applyStimulus(4'b0000, 1'b0);
      checkOutput();
      checkOne("staleResp", {28'h0, resp_valid}, 32'h0);
      modelEdge(4'b0000, 1'b0);
    end
    applyStimulus(4'b1111, 1'b0);
    checkOutput();
    checkOne("ptrAfterReset", {28'h0, grant}, 32'h1);
    modelEdge(4'b1111, 1'b0);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        resetPulse();
      end else begin
        doCycle(4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0));
      end
    end
    for (int n = 0; n < LATENCY + 3; n++) doCycle(4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/cordic_rr_scheduler.md
# cordic_rr_scheduler

Round-robin issue scheduler that shares one 4-stage CORDIC cosine pipeline among NREQ requesters. It grants at most one float32 operand per cycle, drives the pipeline's data and clock-enable, and tracks a requester-ID tag alongside each in-flight operand. Each result is returned to the requester that issued it. It sits between the custom-instruction front ends and the pipelined cosine core.

## Interface
- NREQ, 4: number of requesters (1..8).
- LATENCY, 4: pipeline register stages between `cordic_dataa` and a stable `cordic_result`.
- IDW, 3: tag width; must satisfy 2^IDW >= NREQ.

- clock  in  1  sole clock, rising edge.
- aclr  in  1  asynchronous active-high reset.
- req  in  NREQ  per-requester request level; held until granted.
- req_data  in  32*NREQ  float32 operand; slice i belongs to requester i.
- grant  out  NREQ  one-hot combinational; bit i high means slice i is issued this cycle.
- hold  in  1  freezes the pipeline and the scheduler for the cycle.
- cordic_clk_en  out  1  equals ~hold.
- cordic_aclr  out  1  equals aclr.
- cordic_dataa  out  32  granted operand; 0 when no grant.
- cordic_result  in  32  pipeline output.
- resp_valid  out  NREQ  registered one-hot pulse: result for requester i.
- resp_data  out  32  registered result, valid when any resp_valid bit is high.
- busy  out  1  high while any tag stage is valid.

## Operation
- Arbitration uses a round-robin pointer `ptr`, which resets to 0.
  - Search order is ptr, ptr+1, … mod NREQ. The first requester with req high is granted.
  - No grant is issued when hold=1 or aclr=1.
  - On any grant to requester g, ptr <= (g+1) mod NREQ. ptr is unchanged otherwise.
- The tag pipe has LATENCY stages of {valid, id[IDW-1:0]}. All stages reset to invalid.
  - It advances only when hold=0.
  - On advance, stage0 <= {|grant, index of grant}, and stage k <= stage k-1.
  - Bubbles (no grant) enter as invalid, so the pipeline drains with no further requests.
- Response capture:
  - On each edge with hold=0 and stage LATENCY-1 valid: resp_valid <= onehot(id) and resp_data <= cordic_result.
  - On any other edge: resp_valid <= 0, and resp_data holds its value.
- busy = OR of all stage valid bits (combinational from registers).
- A requester may drop req before being granted with no side effects. Changing req_data while req is high and ungranted is allowed; the value sampled in the grant cycle is the one issued.
- No back-pressure on responses. A requester must accept a resp_valid pulse in the cycle it appears.
- The scheduler imposes no limit on outstanding operations. A single requester may issue every cycle if it is the only one requesting.

## Timing
- Reset values:
  - grant=0, cordic_dataa=0, resp_valid=0, resp_data=0, busy=0, ptr=0, all tags invalid.
  - cordic_clk_en=~hold.
- Reset is asynchronous. Asserting aclr mid-operation discards all in-flight tags; no response is produced for them. The first grant is possible in the first cycle after aclr deasserts.
- Latency with no hold: grant in cycle 0, stage LATENCY-1 valid in cycle LATENCY, resp_valid high in cycle LATENCY+1 (cycle 5 with defaults). It stays high for exactly one cycle.
- Each hold cycle adds one cycle of latency to every in-flight operation. No response is emitted, duplicated or lost across a hold.
- Throughput: one issue per non-hold cycle. Responses leave in issue order.
- A grant and a response for the same requester may occur in the same cycle.
- With NREQ=1, the scheduler grants whenever req=1 and hold=0.

## Test plan
- Single issue:
  - Stimulus: req=0001, req_data[0]=0x3F800000 (1.0), hold=0.
  - Required: grant=0001 in cycle 0, then resp_valid=0001 in cycle 5 only. resp_data equals cordic_result sampled at that edge, ≈0x3F0A514x (cos 1.0). busy is high cycles 1-4.
- Fairness:
  - Stimulus: req=1111 held for 8 cycles.
  - Required: grant sequence 0001,0010,0100,1000,0001,… Responses return in the same order, cycles 5-12, each tagged correctly.
- Hold mid-flight:
  - Stimulus: issue from requester 2 in cycle 0; hold=1 in cycles 2-3.
  - Required: cordic_clk_en=0 in cycles 2-3, no grants during hold, resp_valid=0100 in cycle 7 only.
- Reset mid-flight:
  - Stimulus: issue 3 ops in cycles 0-2; pulse aclr in cycle 3 between edges.
  - Required: all outputs 0 immediately, busy=0, no resp_valid ever for those ops, ptr=0.
- Pointer wrap and skip:
  - Stimulus: last grant to requester 3; then req=0101.
  - Required: grant=0001 next, then 0100, skipping idle requesters 1 and 3.
- Requester withdraw:
  - Stimulus: req[1] asserted while hold=1, then dropped before hold=0.
  - Required: grant[1] never asserted and no response for requester 1.
